generic_write_initiator: RTL
============================

GENERIC_WRITE_INITIATOR -- requirements
Module: generic_write_initiator

Interface
REQ-001 Parameter WIDTH, default 8: write data width in bits.
REQ-002 Parameter DEPTH, default 256: address space; address width AW = $clog2(DEPTH).
REQ-003 Parameter TIMEOUT, default 16, legal range >= 1: WAIT cycles allowed per attempt before retry.
REQ-004 Parameter MAX_RETRIES, default 3, legal range >= 0: re-issues allowed after the first attempt; RW = $clog2(MAX_RETRIES+2).
REQ-005 Clocking: one clock; reset is asynchronous and active-low.
REQ-006 clock  input  1  sole clock; all state updates on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  request offered.
REQ-009 req_ready  output  1  block can accept a request.
REQ-010 req_address  input  AW  target address.
REQ-011 req_data  input  WIDTH  data to write.
REQ-012 req_size  input  $clog2(WIDTH)  bit count to write, forwarded unmodified.
REQ-013 write_clock  output  1  driven directly from clock.
REQ-014 write_address  output  AW  registered address to target.
REQ-015 write_valid  output  1  attempt strobe to target.
REQ-016 write_data  output  WIDTH  registered data to target.
REQ-017 write_size  output  $clog2(WIDTH)  registered size to target.
REQ-018 write_response  input  1  target acknowledge, one-cycle pulse.
REQ-019 done_valid  output  1  one-cycle completion pulse.
REQ-020 done_ok  output  1  1 = acknowledged, 0 = retries exhausted; valid only with done_valid.
REQ-021 done_retries  output  RW  re-issues used; valid only with done_valid.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, DONE; all outputs except write_clock are registered.
REQ-023 req_ready = 1 only in IDLE; acceptance occurs when req_valid && req_ready at a rising edge.
REQ-024 On acceptance: capture address/data/size into write_* registers; clear retry and timeout counters; go to ISSUE.
REQ-025 ISSUE: exactly one cycle with write_valid = 1; write_valid = 0 in all other states.
REQ-026 write_address/data/size hold constant from ISSUE through DONE and keep their last values in IDLE.
REQ-027 write_response is sampled only in ISSUE and WAIT; when high, go to DONE with done_ok = 1.
REQ-028 write_response in IDLE or DONE is ignored and has no effect.
REQ-029 ISSUE without response goes to WAIT; the timeout counter counts WAIT cycles from 0.
REQ-030 At WAIT cycle TIMEOUT with no response: if retries < MAX_RETRIES, increment retries and go to ISSUE; otherwise go to DONE with done_ok = 0.
REQ-031 A response in the same cycle the timeout expires counts as success; no retry occurs.
REQ-032 DONE lasts one cycle with done_valid = 1, done_ok, and done_retries = retries used, then goes to IDLE.
REQ-033 Latency: ISSUE is the cycle after acceptance; DONE is the cycle after the response is sampled.
REQ-034 The retries counter saturates at MAX_RETRIES and never wraps.
REQ-035 A request offered during a busy state is not accepted and is not lost; it is accepted on return to IDLE if still valid.

Reset
REQ-036 While reset_n = 0: state = IDLE, req_ready = 1, write_valid = 0, done_valid = 0, done_ok = 0, done_retries = 0, write_address/data/size = 0, and all counters = 0.
REQ-037 Reset asserted mid-transaction aborts the transaction immediately; no done_valid pulse is generated for it.

Verification
REQ-038 Fast ack: accept at cycle 0 (addr 0x12, data 0xA5, size 7); response in cycle 3 -> write_valid = 1 in cycle 1 only; done_valid = 1, ok = 1, retries = 0 in cycle 4; req_ready = 1 in cycle 5.
REQ-039 No response (TIMEOUT = 4, MAX_RETRIES = 2) -> write_valid = 1 in cycles 1, 6, 11; done_valid = 1, ok = 0, retries = 2 in cycle 16.
REQ-040 Success on retry: response in the second ISSUE cycle -> done_valid = 1, ok = 1, retries = 1 in the following cycle.
REQ-041 Response coincident with the final timeout cycle -> ok = 1 and no further write_valid.
REQ-042 Busy behaviour: req_valid held high during a transaction and stray write_response pulses while IDLE -> no extra acceptance before DONE, stray pulses ignored, next request issued after IDLE.
REQ-043 Reset in WAIT -> all outputs at reset values within the same cycle, and no done_valid after reset release.

Source files
------------

// File: rtl/generic_write_initiator.sv
// generic_write_initiator: issues one write per accepted request, waits for a
// one-cycle acknowledge, re-issues after TIMEOUT silent WAIT cycles up to
// MAX_RETRIES times, then reports the outcome with a one-cycle done pulse.
module generic_write_initiator #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 256,
  parameter int TIMEOUT     = 16,
  parameter int MAX_RETRIES = 3,
  localparam int AW = $clog2(DEPTH),
  localparam int SW = $clog2(WIDTH),
  localparam int RW = $clog2(MAX_RETRIES + 2)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_address,
  input  logic [WIDTH-1:0] req_data,
  input  logic [SW-1:0] req_size,
  output logic          write_clock,
  output logic [AW-1:0] write_address,
  output logic          write_valid,
  output logic [WIDTH-1:0] write_data,
  output logic [SW-1:0] write_size,
  input  logic          write_response,
  output logic          done_valid,
  output logic          done_ok,
  output logic [RW-1:0] done_retries
);

  // Timeout counter only needs to reach TIMEOUT-1 (last WAIT cycle of an attempt)
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            ack_ok;
  logic            accept;

  logic            req_ready_q, req_ready_d;
  logic            write_valid_q, write_valid_d;
  logic            done_valid_q, done_valid_d;
  logic            done_ok_q, done_ok_d;
  logic [RW-1:0]   done_retries_q, done_retries_d;
  logic [AW-1:0]   write_address_q, write_address_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [SW-1:0]   write_size_q, write_size_d;

  assign accept = (state_q == S_IDLE) && req_valid;

  // State and attempt counters
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      retry_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next state; the response wins over an expiring timeout in the same cycle
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    tmo_d   = '0;
    ack_ok  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_ISSUE;
          retry_d = '0;
        end
      end
      S_ISSUE: begin
        if (write_response) begin
          state_d = S_DONE;
          ack_ok  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (write_response) begin
          state_d = S_DONE;
          ack_ok  = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output next-values decoded from the upcoming state so every output is a flop
  always_comb begin
    req_ready_d     = (state_d == S_IDLE);
    write_valid_d   = (state_d == S_ISSUE);
    done_valid_d    = (state_d == S_DONE);
    done_ok_d       = ack_ok;
    done_retries_d  = (state_d == S_DONE) ? retry_q : '0;
    write_address_d = accept ? req_address : write_address_q;
    write_data_d    = accept ? req_data    : write_data_q;
    write_size_d    = accept ? req_size    : write_size_q;
  end

  // Output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_ready_q     <= 1'b1;
      write_valid_q   <= 1'b0;
      done_valid_q    <= 1'b0;
      done_ok_q       <= 1'b0;
      done_retries_q  <= '0;
      write_address_q <= '0;
      write_data_q    <= '0;
      write_size_q    <= '0;
    end else begin
      req_ready_q     <= req_ready_d;
      write_valid_q   <= write_valid_d;
      done_valid_q    <= done_valid_d;
      done_ok_q       <= done_ok_d;
      done_retries_q  <= done_retries_d;
      write_address_q <= write_address_d;
      write_data_q    <= write_data_d;
      write_size_q    <= write_size_d;
    end
  end

  assign write_clock   = clock;
  assign req_ready     = req_ready_q;
  assign write_valid   = write_valid_q;
  assign done_valid    = done_valid_q;
  assign done_ok       = done_ok_q;
  assign done_retries  = done_retries_q;
  assign write_address = write_address_q;
  assign write_data    = write_data_q;
  assign write_size    = write_size_q;

endmodule
